// File: rtl/axi_mem_outstanding_limiter.sv
// AXI4 pass-through that caps in-flight read and write bursts independently.
// Only AR/AW valid/ready are gated; every other channel is a straight wire.
// Also reports outstanding counts, sticky underflow and response-watchdog flags.
module axi_mem_outstanding_limiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int ID_WIDTH   = 4,
    parameter int MAX_RD     = 8,
    parameter int MAX_WR     = 8,
    parameter int TIMEOUT    = 65535
) (
    input  logic                    uncoreclk,
    input  logic                    uncorersts,
    // slave side AW/W/B
    input  logic [ID_WIDTH-1:0]     s_axi_awid,
    input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [7:0]              s_axi_awlen,
    input  logic [2:0]              s_axi_awsize,
    input  logic [1:0]              s_axi_awburst,
    input  logic                    s_axi_awlock,
    input  logic [3:0]              s_axi_awcache,
    input  logic [2:0]              s_axi_awprot,
    input  logic [3:0]              s_axi_awqos,
    input  logic                    s_axi_awvalid,
    output logic                    s_axi_awready,
    input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                    s_axi_wlast,
    input  logic                    s_axi_wvalid,
    output logic                    s_axi_wready,
    output logic [ID_WIDTH-1:0]     s_axi_bid,
    output logic [1:0]              s_axi_bresp,
    output logic                    s_axi_bvalid,
    input  logic                    s_axi_bready,
    // slave side AR/R
    input  logic [ID_WIDTH-1:0]     s_axi_arid,
    input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic [7:0]              s_axi_arlen,
    input  logic [2:0]              s_axi_arsize,
    input  logic [1:0]              s_axi_arburst,
    input  logic                    s_axi_arlock,
    input  logic [3:0]              s_axi_arcache,
    input  logic [2:0]              s_axi_arprot,
    input  logic [3:0]              s_axi_arqos,
    input  logic                    s_axi_arvalid,
    output logic                    s_axi_arready,
    output logic [ID_WIDTH-1:0]     s_axi_rid,
    output logic [DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]              s_axi_rresp,
    output logic                    s_axi_rlast,
    output logic                    s_axi_rvalid,
    input  logic                    s_axi_rready,
    // master side AW/W/B
    output logic [ID_WIDTH-1:0]     m_axi_awid,
    output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [7:0]              m_axi_awlen,
    output logic [2:0]              m_axi_awsize,
    output logic [1:0]              m_axi_awburst,
    output logic                    m_axi_awlock,
    output logic [3:0]              m_axi_awcache,
    output logic [2:0]              m_axi_awprot,
    output logic [3:0]              m_axi_awqos,
    output logic                    m_axi_awvalid,
    input  logic                    m_axi_awready,
    output logic [DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                    m_axi_wlast,
    output logic                    m_axi_wvalid,
    input  logic                    m_axi_wready,
    input  logic [ID_WIDTH-1:0]     m_axi_bid,
    input  logic [1:0]              m_axi_bresp,
    input  logic                    m_axi_bvalid,
    output logic                    m_axi_bready,
    // master side AR/R
    output logic [ID_WIDTH-1:0]     m_axi_arid,
    output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
    output logic [7:0]              m_axi_arlen,
    output logic [2:0]              m_axi_arsize,
    output logic [1:0]              m_axi_arburst,
    output logic                    m_axi_arlock,
    output logic [3:0]              m_axi_arcache,
    output logic [2:0]              m_axi_arprot,
    output logic [3:0]              m_axi_arqos,
    output logic                    m_axi_arvalid,
    input  logic                    m_axi_arready,
    input  logic [ID_WIDTH-1:0]     m_axi_rid,
    input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
    input  logic [1:0]              m_axi_rresp,
    input  logic                    m_axi_rlast,
    input  logic                    m_axi_rvalid,
    output logic                    m_axi_rready,
    // status
    output logic [7:0]              rd_outstanding,
    output logic [7:0]              wr_outstanding,
    output logic                    err_timeout,
    output logic                    err_underflow
);

    logic [7:0]  rd_cnt_q, rd_cnt_d;
    logic [7:0]  wr_cnt_q, wr_cnt_d;
    logic [15:0] wd_cnt_q, wd_cnt_d;
    logic        err_timeout_q, err_timeout_d;
    logic        err_underflow_q, err_underflow_d;
    logic        rd_full, wr_full;
    logic        rd_inc, rd_dec, wr_inc, wr_dec;
    logic        rd_unf, wr_unf;
    logic        resp_hs, idle;

    // Gate on the registered count only, so a forwarded AR/AW can never be withdrawn.
    assign rd_full = (rd_cnt_q == 8'(MAX_RD));
    assign wr_full = (wr_cnt_q == 8'(MAX_WR));

    assign m_axi_awid    = s_axi_awid;
    assign m_axi_awaddr  = s_axi_awaddr;
    assign m_axi_awlen   = s_axi_awlen;
    assign m_axi_awsize  = s_axi_awsize;
    assign m_axi_awburst = s_axi_awburst;
    assign m_axi_awlock  = s_axi_awlock;
    assign m_axi_awcache = s_axi_awcache;
    assign m_axi_awprot  = s_axi_awprot;
    assign m_axi_awqos   = s_axi_awqos;
    assign m_axi_awvalid = s_axi_awvalid & ~wr_full;
    assign s_axi_awready = m_axi_awready & ~wr_full;

    // W is never gated: early write data is legal and goes straight through.
    assign m_axi_wdata   = s_axi_wdata;
    assign m_axi_wstrb   = s_axi_wstrb;
    assign m_axi_wlast   = s_axi_wlast;
    assign m_axi_wvalid  = s_axi_wvalid;
    assign s_axi_wready  = m_axi_wready;

    assign s_axi_bid     = m_axi_bid;
    assign s_axi_bresp   = m_axi_bresp;
    assign s_axi_bvalid  = m_axi_bvalid;
    assign m_axi_bready  = s_axi_bready;

    assign m_axi_arid    = s_axi_arid;
    assign m_axi_araddr  = s_axi_araddr;
    assign m_axi_arlen   = s_axi_arlen;
    assign m_axi_arsize  = s_axi_arsize;
    assign m_axi_arburst = s_axi_arburst;
    assign m_axi_arlock  = s_axi_arlock;
    assign m_axi_arcache = s_axi_arcache;
    assign m_axi_arprot  = s_axi_arprot;
    assign m_axi_arqos   = s_axi_arqos;
    assign m_axi_arvalid = s_axi_arvalid & ~rd_full;
    assign s_axi_arready = m_axi_arready & ~rd_full;

    assign s_axi_rid     = m_axi_rid;
    assign s_axi_rdata   = m_axi_rdata;
    assign s_axi_rresp   = m_axi_rresp;
    assign s_axi_rlast   = m_axi_rlast;
    assign s_axi_rvalid  = m_axi_rvalid;
    assign m_axi_rready  = s_axi_rready;

    assign rd_inc  = m_axi_arvalid & m_axi_arready;
    assign rd_dec  = m_axi_rvalid & m_axi_rready & m_axi_rlast;
    assign wr_inc  = m_axi_awvalid & m_axi_awready;
    assign wr_dec  = m_axi_bvalid & m_axi_bready;
    assign resp_hs = (m_axi_rvalid & m_axi_rready) | (m_axi_bvalid & m_axi_bready);
    assign idle    = (rd_cnt_q == 8'd0) && (wr_cnt_q == 8'd0);

    // Next-state for counts, watchdog and sticky flags.
    always_comb begin
        rd_cnt_d = rd_cnt_q;
        wr_cnt_d = wr_cnt_q;
        rd_unf   = 1'b0;
        wr_unf   = 1'b0;

        if (rd_inc && !rd_dec) begin
            rd_cnt_d = rd_cnt_q + 8'd1;
        end else if (rd_dec && !rd_inc) begin
            if (rd_cnt_q == 8'd0) rd_unf = 1'b1;
            else                  rd_cnt_d = rd_cnt_q - 8'd1;
        end

        if (wr_inc && !wr_dec) begin
            wr_cnt_d = wr_cnt_q + 8'd1;
        end else if (wr_dec && !wr_inc) begin
            if (wr_cnt_q == 8'd0) wr_unf = 1'b1;
            else                  wr_cnt_d = wr_cnt_q - 8'd1;
        end

        if (resp_hs || idle)          wd_cnt_d = 16'd0;
        else if (wd_cnt_q == 16'hFFFF) wd_cnt_d = wd_cnt_q;
        else                          wd_cnt_d = wd_cnt_q + 16'd1;

        // Compare the next value so the flag rises on the same edge the count hits TIMEOUT.
        err_timeout_d   = err_timeout_q | (wd_cnt_d == 16'(TIMEOUT));
        err_underflow_d = err_underflow_q | rd_unf | wr_unf;
    end

    // State registers with synchronous reset.
    always_ff @(posedge uncoreclk) begin
        if (uncorersts) begin
            rd_cnt_q        <= 8'd0;
            wr_cnt_q        <= 8'd0;
            wd_cnt_q        <= 16'd0;
            err_timeout_q   <= 1'b0;
            err_underflow_q <= 1'b0;
        end else begin
            rd_cnt_q        <= rd_cnt_d;
            wr_cnt_q        <= wr_cnt_d;
            wd_cnt_q        <= wd_cnt_d;
            err_timeout_q   <= err_timeout_d;
            err_underflow_q <= err_underflow_d;
        end
    end

    assign rd_outstanding = rd_cnt_q;
    assign wr_outstanding = wr_cnt_q;
    assign err_timeout    = err_timeout_q;
    assign err_underflow  = err_underflow_q;

endmodule

// File: tb/tb_axi_mem_outstanding_limiter.sv
// Directed bench for axi_mem_outstanding_limiter with payload scoreboards per channel.
module tb_axi_mem_outstanding_limiter;

    logic        uncoreclk = 1'b0;
    logic        uncorersts = 1'b1;

    logic [3:0]  s_axi_awid;   logic [31:0] s_axi_awaddr; logic [7:0] s_axi_awlen;
    logic [2:0]  s_axi_awsize; logic [1:0]  s_axi_awburst; logic s_axi_awlock;
    logic [3:0]  s_axi_awcache; logic [2:0] s_axi_awprot; logic [3:0] s_axi_awqos;
    logic        s_axi_awvalid, s_axi_awready;
    logic [63:0] s_axi_wdata;  logic [7:0]  s_axi_wstrb;  logic s_axi_wlast, s_axi_wvalid, s_axi_wready;
    logic [3:0]  s_axi_bid;    logic [1:0]  s_axi_bresp;  logic s_axi_bvalid, s_axi_bready;
    logic [3:0]  s_axi_arid;   logic [31:0] s_axi_araddr; logic [7:0] s_axi_arlen;
    logic [2:0]  s_axi_arsize; logic [1:0]  s_axi_arburst; logic s_axi_arlock;
    logic [3:0]  s_axi_arcache; logic [2:0] s_axi_arprot; logic [3:0] s_axi_arqos;
    logic        s_axi_arvalid, s_axi_arready;
    logic [3:0]  s_axi_rid;    logic [63:0] s_axi_rdata;  logic [1:0] s_axi_rresp;
    logic        s_axi_rlast, s_axi_rvalid, s_axi_rready;

    logic [3:0]  m_axi_awid;   logic [31:0] m_axi_awaddr; logic [7:0] m_axi_awlen;
    logic [2:0]  m_axi_awsize; logic [1:0]  m_axi_awburst; logic m_axi_awlock;
    logic [3:0]  m_axi_awcache; logic [2:0] m_axi_awprot; logic [3:0] m_axi_awqos;
    logic        m_axi_awvalid, m_axi_awready;
    logic [63:0] m_axi_wdata;  logic [7:0]  m_axi_wstrb;  logic m_axi_wlast, m_axi_wvalid, m_axi_wready;
    logic [3:0]  m_axi_bid;    logic [1:0]  m_axi_bresp;  logic m_axi_bvalid, m_axi_bready;
    logic [3:0]  m_axi_arid;   logic [31:0] m_axi_araddr; logic [7:0] m_axi_arlen;
    logic [2:0]  m_axi_arsize; logic [1:0]  m_axi_arburst; logic m_axi_arlock;
    logic [3:0]  m_axi_arcache; logic [2:0] m_axi_arprot; logic [3:0] m_axi_arqos;
    logic        m_axi_arvalid, m_axi_arready;
    logic [3:0]  m_axi_rid;    logic [63:0] m_axi_rdata;  logic [1:0] m_axi_rresp;
    logic        m_axi_rlast, m_axi_rvalid, m_axi_rready;

    logic [7:0]  rd_outstanding, wr_outstanding;
    logic        err_timeout, err_underflow;

    int checks = 0;
    int errors = 0;

    logic [127:0] ar_q[$];
    logic [127:0] aw_q[$];
    logic [127:0] w_q[$];
    logic [127:0] b_q[$];
    logic [127:0] r_q[$];

    axi_mem_outstanding_limiter #(
        .ADDR_WIDTH(32), .DATA_WIDTH(64), .ID_WIDTH(4),
        .MAX_RD(2), .MAX_WR(2), .TIMEOUT(10)
    ) dut (
        .uncoreclk(uncoreclk), .uncorersts(uncorersts),
        .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
        .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst), .s_axi_awlock(s_axi_awlock),
        .s_axi_awcache(s_axi_awcache), .s_axi_awprot(s_axi_awprot), .s_axi_awqos(s_axi_awqos),
        .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
        .s_axi_bready(s_axi_bready),
        .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
        .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst), .s_axi_arlock(s_axi_arlock),
        .s_axi_arcache(s_axi_arcache), .s_axi_arprot(s_axi_arprot), .s_axi_arqos(s_axi_arqos),
        .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
        .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
        .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awlock(m_axi_awlock),
        .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot), .m_axi_awqos(m_axi_awqos),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
        .m_axi_bready(m_axi_bready),
        .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
        .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock),
        .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot), .m_axi_arqos(m_axi_arqos),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
        .rd_outstanding(rd_outstanding), .wr_outstanding(wr_outstanding),
        .err_timeout(err_timeout), .err_underflow(err_underflow)
    );

    always #5 uncoreclk = ~uncoreclk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge uncoreclk);
        #1;
    endtask

    task automatic settle();
        @(negedge uncoreclk);
    endtask

    task automatic send_ar(input logic [31:0] addr);
        s_axi_arvalid = 1'b1; s_axi_araddr = addr; s_axi_arid = addr[5:2];
        s_axi_arlen = addr[7:0] ^ 8'h3C; s_axi_arsize = 3'd3; s_axi_arburst = 2'b01;
        s_axi_arlock = addr[2]; s_axi_arcache = 4'h3; s_axi_arprot = 3'b010; s_axi_arqos = addr[11:8];
        ar_q.push_back({s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst,
                        s_axi_arlock, s_axi_arcache, s_axi_arprot, s_axi_arqos});
    endtask

    task automatic send_aw(input logic [31:0] addr);
        s_axi_awvalid = 1'b1; s_axi_awaddr = addr; s_axi_awid = addr[5:2];
        s_axi_awlen = addr[7:0] ^ 8'hA5; s_axi_awsize = 3'd2; s_axi_awburst = 2'b10;
        s_axi_awlock = ~addr[2]; s_axi_awcache = 4'hF; s_axi_awprot = 3'b101; s_axi_awqos = addr[11:8];
        aw_q.push_back({s_axi_awid, s_axi_awaddr, s_axi_awlen, s_axi_awsize, s_axi_awburst,
                        s_axi_awlock, s_axi_awcache, s_axi_awprot, s_axi_awqos});
    endtask

    task automatic send_w(input logic [63:0] data, input logic [7:0] strb, input logic last);
        s_axi_wvalid = 1'b1; s_axi_wdata = data; s_axi_wstrb = strb; s_axi_wlast = last;
        w_q.push_back({data, strb, last});
    endtask

    task automatic send_b(input logic [3:0] id, input logic [1:0] resp);
        m_axi_bvalid = 1'b1; m_axi_bid = id; m_axi_bresp = resp;
        b_q.push_back({id, resp});
    endtask

    task automatic send_r(input logic [3:0] id, input logic [63:0] data, input logic last);
        m_axi_rvalid = 1'b1; m_axi_rid = id; m_axi_rdata = data; m_axi_rresp = 2'b00; m_axi_rlast = last;
        r_q.push_back({id, data, 2'b00, last});
    endtask

    // Scoreboard: every handshake that reaches the far side must match the oldest driven payload.
    always @(negedge uncoreclk) begin
        if (!uncorersts) begin
            if (m_axi_arvalid && m_axi_arready) begin
                if (ar_q.size() == 0) check("ar_unexpected", 1, 0);
                else check("ar_payload", {m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize,
                           m_axi_arburst, m_axi_arlock, m_axi_arcache, m_axi_arprot, m_axi_arqos},
                           ar_q.pop_front());
            end
            if (m_axi_awvalid && m_axi_awready) begin
                if (aw_q.size() == 0) check("aw_unexpected", 1, 0);
                else check("aw_payload", {m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize,
                           m_axi_awburst, m_axi_awlock, m_axi_awcache, m_axi_awprot, m_axi_awqos},
                           aw_q.pop_front());
            end
            if (m_axi_wvalid && m_axi_wready) begin
                if (w_q.size() == 0) check("w_unexpected", 1, 0);
                else check("w_payload", {m_axi_wdata, m_axi_wstrb, m_axi_wlast}, w_q.pop_front());
            end
            if (s_axi_bvalid && s_axi_bready) begin
                if (b_q.size() == 0) check("b_unexpected", 1, 0);
                else check("b_payload", {s_axi_bid, s_axi_bresp}, b_q.pop_front());
            end
            if (s_axi_rvalid && s_axi_rready) begin
                if (r_q.size() == 0) check("r_unexpected", 1, 0);
                else check("r_payload", {s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast}, r_q.pop_front());
            end
        end
    end

    initial begin
        s_axi_awid = '0; s_axi_awaddr = '0; s_axi_awlen = '0; s_axi_awsize = '0; s_axi_awburst = '0;
        s_axi_awlock = 1'b0; s_axi_awcache = '0; s_axi_awprot = '0; s_axi_awqos = '0; s_axi_awvalid = 1'b0;
        s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wlast = 1'b0; s_axi_wvalid = 1'b0; s_axi_bready = 1'b1;
        s_axi_arid = '0; s_axi_araddr = '0; s_axi_arlen = '0; s_axi_arsize = '0; s_axi_arburst = '0;
        s_axi_arlock = 1'b0; s_axi_arcache = '0; s_axi_arprot = '0; s_axi_arqos = '0; s_axi_arvalid = 1'b0;
        s_axi_rready = 1'b1;
        m_axi_awready = 1'b1; m_axi_wready = 1'b1; m_axi_arready = 1'b1;
        m_axi_bid = '0; m_axi_bresp = '0; m_axi_bvalid = 1'b0;
        m_axi_rid = '0; m_axi_rdata = '0; m_axi_rresp = '0; m_axi_rlast = 1'b0; m_axi_rvalid = 1'b0;

        // Reset state
        repeat (2) tick();
        settle();
        check("rst_rd_out", rd_outstanding, 0);
        check("rst_wr_out", wr_outstanding, 0);
        check("rst_err_to", err_timeout, 0);
        check("rst_err_uf", err_underflow, 0);
        check("rst_arready", s_axi_arready, 1);
        check("rst_arvalid", m_axi_arvalid, 0);
        check("rst_bready", m_axi_bready, 1);
        check("rst_rready", m_axi_rready, 1);
        tick(); uncorersts = 1'b0;

        // Three back-to-back ARs against MAX_RD=2
        send_ar(32'h0000_0100);
        settle(); check("ar0_ready", s_axi_arready, 1);
        tick(); send_ar(32'h0000_0104);
        settle(); check("ar1_ready", s_axi_arready, 1); check("ar1_rd_out", rd_outstanding, 1);
        tick(); send_ar(32'h0000_0108);
        settle();
        check("ar2_blk_ready", s_axi_arready, 0);
        check("ar2_blk_valid", m_axi_arvalid, 0);
        check("ar2_rd_out", rd_outstanding, 2);
        tick(); settle();
        check("ar2_still_blk", s_axi_arready, 0);

        // Last R beat: same cycle stays blocked, next cycle the held AR goes
        tick(); send_r(4'h2, 64'hA5A5_0123_4567_89AB, 1'b1);
        settle();
        check("r_same_cyc_ready", s_axi_arready, 0);
        check("r_same_cyc_valid", m_axi_arvalid, 0);
        check("r_same_cyc_rd_out", rd_outstanding, 2);
        tick(); m_axi_rvalid = 1'b0;
        settle();
        check("ar2_go_ready", s_axi_arready, 1);
        check("ar2_go_valid", m_axi_arvalid, 1);
        check("ar2_go_rd_out", rd_outstanding, 1);
        tick(); s_axi_arvalid = 1'b0;
        settle(); check("ar2_done_rd_out", rd_outstanding, 2);

        // Early W, then AW, then AW and B in the same cycle
        tick(); send_w(64'h1111_2222_3333_4444, 8'h5A, 1'b1);
        settle();
        check("w_early_wready", s_axi_wready, 1);
        check("w_early_awvalid", m_axi_awvalid, 0);
        check("w_early_wr_out", wr_outstanding, 0);
        tick(); s_axi_wvalid = 1'b0; send_aw(32'h0000_0200);
        settle(); check("aw0_ready", s_axi_awready, 1);
        tick(); send_aw(32'h0000_0204); send_b(4'h3, 2'b00);
        settle();
        check("awb_awvalid", m_axi_awvalid, 1);
        check("awb_wr_out_pre", wr_outstanding, 1);
        tick(); s_axi_awvalid = 1'b0; m_axi_bvalid = 1'b0;
        settle(); check("awb_wr_out", wr_outstanding, 1);

        // Let the watchdog fire, then reset mid-operation with rd=2, wr=1
        repeat (12) tick();
        settle();
        check("pre_rst_err_to", err_timeout, 1);
        check("pre_rst_rd_out", rd_outstanding, 2);
        check("pre_rst_wr_out", wr_outstanding, 1);
        tick(); uncorersts = 1'b1;
        tick(); uncorersts = 1'b0; send_ar(32'h0000_0300);
        settle();
        check("midrst_rd_out", rd_outstanding, 0);
        check("midrst_wr_out", wr_outstanding, 0);
        check("midrst_err_to", err_timeout, 0);
        check("midrst_err_uf", err_underflow, 0);
        check("midrst_ar_ready", s_axi_arready, 1);
        check("midrst_ar_valid", m_axi_arvalid, 1);
        tick(); s_axi_arvalid = 1'b0;
        settle(); check("midrst_ar_rd_out", rd_outstanding, 1);

        // Lone B with wr_cnt=0
        tick(); send_b(4'h5, 2'b10);
        tick(); m_axi_bvalid = 1'b0;
        settle();
        check("uf_wr_out", wr_outstanding, 0);
        check("uf_flag", err_underflow, 1);
        repeat (3) tick();
        settle(); check("uf_sticky", err_underflow, 1);
        tick(); uncorersts = 1'b1;
        tick(); uncorersts = 1'b0;
        settle();
        check("uf_cleared", err_underflow, 0);
        check("uf_rst_rd_out", rd_outstanding, 0);

        // Watchdog timing: flag rises exactly 10 cycles after the AR handshake
        tick(); send_ar(32'h0000_0400);
        tick(); s_axi_arvalid = 1'b0;
        settle();
        check("to_e0", err_timeout, 0);
        check("to_rd_out", rd_outstanding, 1);
        for (int k = 1; k <= 9; k++) begin
            tick(); settle();
            check($sformatf("to_e%0d", k), err_timeout, 0);
        end
        tick(); settle();
        check("to_e10", err_timeout, 1);
        tick(); send_r(4'h7, 64'hDEAD_BEEF_0000_0042, 1'b1);
        tick(); m_axi_rvalid = 1'b0;
        settle();
        check("to_after_r_rd_out", rd_outstanding, 0);
        check("to_sticky", err_timeout, 1);

        // Every driven payload must have been seen on the far side
        tick(); settle();
        check("sb_ar_empty", ar_q.size(), 0);
        check("sb_aw_empty", aw_q.size(), 0);
        check("sb_w_empty", w_q.size(), 0);
        check("sb_b_empty", b_q.size(), 0);
        check("sb_r_empty", r_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
